// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared opcodes, FSM states and PC-select codes for cpu_ctrl  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_pkg;

   localparam logic [6:0] OP_ALUREG = 7'b0110011;
   localparam logic [6:0] OP_ALUIMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      ST_FETCH_INSTR = 4'd0,
      ST_WAIT_INSTR  = 4'd1,
      ST_FETCH_REGS  = 4'd2,
      ST_EXECUTE     = 4'd3,
      ST_LOAD        = 4'd4,
      ST_WAIT_DATA   = 4'd5,
      ST_STORE       = 4'd6,
      ST_WAIT_STORE  = 4'd7,
      ST_HALT        = 4'd8
   } state_t;

   localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
   localparam logic [1:0] PCSEL_IMM   = 2'd1;
   localparam logic [1:0] PCSEL_RS1   = 2'd2;

   typedef struct packed {
      logic alu;
      logic jal;
      logic jalr;
      logic branch;
      logic load;
      logic store;
      logic system;
   } opclass_t;

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_opdec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_opdec: opcode to one-hot instruction class, plus illegal     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cpu_ctrl_opdec
   import cpu_pkg::*;
(
   input  logic [6:0] i_opcode,
   output opclass_t   o_class,
   output logic       o_illegal
);

   always_comb begin
      o_class = '0;
      case (i_opcode)
         OP_ALUREG, OP_ALUIMM, OP_LUI, OP_AUIPC: o_class.alu    = 1'b1;
         OP_JAL:                                 o_class.jal    = 1'b1;
         OP_JALR:                                o_class.jalr   = 1'b1;
         OP_BRANCH:                              o_class.branch = 1'b1;
         OP_LOAD:                                o_class.load   = 1'b1;
         OP_STORE:                               o_class.store  = 1'b1;
         OP_SYSTEM:                              o_class.system = 1'b1;
         default:                                o_class        = '0;
      endcase
      o_illegal = (o_class == '0);
   end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl: multi-cycle RV32I sequencer driving datapath and memory     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cpu_ctrl
   import cpu_pkg::*;
#(
   parameter int HALT_ON_SYSTEM = 1,
   parameter int BUSY_TIMEOUT   = 0,
   parameter int TMO_W          = 16
)(
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] opcode,
   input  logic       take_branch,
   input  logic       mem_rbusy,
   input  logic       mem_wbusy,
   output logic       mem_rstrb,
   output logic       mem_wstrb,
   output logic       addr_sel,
   output logic       instr_we,
   output logic       regs_re,
   output logic       rd_we,
   output logic       wb_sel,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       retire,
   output logic       halted,
   output logic       err_illegal,
   output logic       err_timeout,
   output logic [3:0] state
);

   localparam logic             c_TMO_EN   = (BUSY_TIMEOUT != 0);
   localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

   state_t           r_state;
   logic [TMO_W-1:0] r_cnt;
   logic             r_err_illegal;
   logic             r_err_timeout;

   state_t           w_next;
   opclass_t         w_class;
   logic             w_illegal;
   logic             w_tmo;
   logic             w_busy;
   logic             w_enter_wait;
   logic             w_set_ill;
   logic             w_set_tmo;
   logic             w_rstrb, w_wstrb, w_addr_sel, w_instr_we, w_regs_re;
   logic             w_rd_we, w_wb_sel, w_pc_we, w_retire, w_halted;
   logic [1:0]       w_pc_sel;

   cpu_ctrl_opdec u_opdec (
      .i_opcode  (opcode),
      .o_class   (w_class),
      .o_illegal (w_illegal)
   );

   assign w_tmo = c_TMO_EN && (r_cnt == c_TMO_LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state       <= ST_FETCH_INSTR;
         r_cnt         <= '0;
         r_err_illegal <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_enter_wait)
            r_cnt <= '0;
         else if (w_busy && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
         if (w_set_ill)
            r_err_illegal <= 1'b1;
         if (w_set_tmo)
            r_err_timeout <= 1'b1;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_busy     = 1'b0;
      w_set_ill  = 1'b0;
      w_set_tmo  = 1'b0;
      w_rstrb    = 1'b0;
      w_wstrb    = 1'b0;
      w_addr_sel = 1'b0;
      w_instr_we = 1'b0;
      w_regs_re  = 1'b0;
      w_rd_we    = 1'b0;
      w_wb_sel   = 1'b0;
      w_pc_we    = 1'b0;
      w_pc_sel   = PCSEL_PLUS4;
      w_retire   = 1'b0;
      w_halted   = 1'b0;
      case (r_state)
         ST_FETCH_INSTR: begin
            w_rstrb = 1'b1;
            w_next  = ST_WAIT_INSTR;
         end
         ST_WAIT_INSTR: begin
            if (!mem_rbusy) begin
               w_instr_we = 1'b1;
               w_next     = ST_FETCH_REGS;
            end else if (w_tmo) begin
               w_set_tmo = 1'b1;
               w_next    = ST_HALT;
            end else begin
               w_busy = 1'b1;
            end
         end
         ST_FETCH_REGS: begin
            w_regs_re = 1'b1;
            w_next    = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            w_next = ST_FETCH_INSTR;
            if (w_class.alu || w_class.jal || w_class.jalr) begin
               w_rd_we  = 1'b1;
               w_pc_we  = 1'b1;
               w_retire = 1'b1;
               w_pc_sel = w_class.jal  ? PCSEL_IMM :
                          w_class.jalr ? PCSEL_RS1 : PCSEL_PLUS4;
            end else if (w_class.branch) begin
               w_pc_we  = 1'b1;
               w_retire = 1'b1;
               w_pc_sel = take_branch ? PCSEL_IMM : PCSEL_PLUS4;
            end else if (w_class.load || w_class.store) begin
               w_pc_we = 1'b1;
               w_next  = w_class.load ? ST_LOAD : ST_STORE;
            end else if (w_class.system) begin
               if (HALT_ON_SYSTEM != 0) begin
                  w_next = ST_HALT;
               end else begin
                  w_pc_we  = 1'b1;
                  w_retire = 1'b1;
               end
            end else if (w_illegal) begin
               w_set_ill = 1'b1;
               w_next    = ST_HALT;
            end
         end
         ST_LOAD: begin
            w_rstrb    = 1'b1;
            w_addr_sel = 1'b1;
            w_next     = ST_WAIT_DATA;
         end
         ST_WAIT_DATA: begin
            w_addr_sel = 1'b1;
            if (!mem_rbusy) begin
               w_rd_we  = 1'b1;
               w_wb_sel = 1'b1;
               w_retire = 1'b1;
               w_next   = ST_FETCH_INSTR;
            end else if (w_tmo) begin
               w_set_tmo = 1'b1;
               w_next    = ST_HALT;
            end else begin
               w_busy = 1'b1;
            end
         end
         ST_STORE: begin
            w_wstrb    = 1'b1;
            w_addr_sel = 1'b1;
            w_next     = ST_WAIT_STORE;
         end
         ST_WAIT_STORE: begin
            if (!mem_wbusy) begin
               w_retire = 1'b1;
               w_next   = ST_FETCH_INSTR;
            end else if (w_tmo) begin
               w_set_tmo = 1'b1;
               w_next    = ST_HALT;
            end else begin
               w_busy = 1'b1;
            end
         end
         ST_HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            w_next = ST_HALT;
         end
      endcase
      // The counter restarts whenever a wait state is freshly entered
      w_enter_wait = (w_next != r_state) &&
                     ((w_next == ST_WAIT_INSTR) || (w_next == ST_WAIT_DATA) ||
                      (w_next == ST_WAIT_STORE));
   end

   assign mem_rstrb   = resetn & w_rstrb;
   assign mem_wstrb   = resetn & w_wstrb;
   assign addr_sel    = resetn & w_addr_sel;
   assign instr_we    = resetn & w_instr_we;
   assign regs_re     = resetn & w_regs_re;
   assign rd_we       = resetn & w_rd_we;
   assign wb_sel      = resetn & w_wb_sel;
   assign pc_we       = resetn & w_pc_we;
   assign pc_sel      = resetn ? w_pc_sel : 2'b00;
   assign retire      = resetn & w_retire;
   assign halted      = resetn & w_halted;
   assign err_illegal = resetn & r_err_illegal;
   assign err_timeout = resetn & r_err_timeout;
   assign state       = resetn ? r_state : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_ctrl: directed vectors with a queued expected-output scoreboard|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cpu_ctrl;
   import cpu_pkg::*;

   typedef struct packed {
      logic       rs;
      logic       ws;
      logic       as;
      logic       iw;
      logic       rr;
      logic       rw;
      logic       wb;
      logic       pw;
      logic [1:0] ps;
      logic       rt;
      logic       h;
      logic       ei;
      logic       et;
      logic [3:0] st;
   } out_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic [6:0] opcode;
   logic       take_branch;
   logic       mem_rbusy;
   logic       mem_wbusy;
   logic       mem_rstrb, mem_wstrb, addr_sel, instr_we, regs_re;
   logic       rd_we, wb_sel, pc_we, retire, halted, err_illegal, err_timeout;
   logic [1:0] pc_sel;
   logic [3:0] state;
   out_t       act;

   out_t       q_exp[$];
   string      q_name[$];
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   cpu_ctrl #(
      .HALT_ON_SYSTEM (1),
      .BUSY_TIMEOUT   (8),
      .TMO_W          (16)
   ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .opcode      (opcode),
      .take_branch (take_branch),
      .mem_rbusy   (mem_rbusy),
      .mem_wbusy   (mem_wbusy),
      .mem_rstrb   (mem_rstrb),
      .mem_wstrb   (mem_wstrb),
      .addr_sel    (addr_sel),
      .instr_we    (instr_we),
      .regs_re     (regs_re),
      .rd_we       (rd_we),
      .wb_sel      (wb_sel),
      .pc_we       (pc_we),
      .pc_sel      (pc_sel),
      .retire      (retire),
      .halted      (halted),
      .err_illegal (err_illegal),
      .err_timeout (err_timeout),
      .state       (state)
   );

   assign act = {mem_rstrb, mem_wstrb, addr_sel, instr_we, regs_re, rd_we, wb_sel,
                 pc_we, pc_sel, retire, halted, err_illegal, err_timeout, state};

   // Letters: r=rstrb w=wstrb a=addr_sel i=instr_we g=regs_re d=rd_we
   // l=wb_sel p=pc_we t=retire h=halted x=err_illegal o=err_timeout
   function automatic out_t E(input logic [3:0] st, input string f,
                              input logic [1:0] ps = PCSEL_PLUS4);
      out_t e;
      e    = '0;
      e.st = st;
      e.ps = ps;
      for (int i = 0; i < f.len(); i++) begin
         case (f[i])
            "r": e.rs = 1'b1;
            "w": e.ws = 1'b1;
            "a": e.as = 1'b1;
            "i": e.iw = 1'b1;
            "g": e.rr = 1'b1;
            "d": e.rw = 1'b1;
            "l": e.wb = 1'b1;
            "p": e.pw = 1'b1;
            "t": e.rt = 1'b1;
            "h": e.h  = 1'b1;
            "x": e.ei = 1'b1;
            "o": e.et = 1'b1;
            default: ;
         endcase
      end
      return e;
   endfunction

   task automatic cyc(input string nm, input logic rn, input logic rb,
                      input logic wb, input out_t e);
      resetn    = rn;
      mem_rbusy = rb;
      mem_wbusy = wb;
      q_exp.push_back(e);
      q_name.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic front(input string nm);
      cyc({nm, "/F"},  1'b1, 1'b0, 1'b0, E(ST_FETCH_INSTR, "r"));
      cyc({nm, "/WI"}, 1'b1, 1'b0, 1'b0, E(ST_WAIT_INSTR, "i"));
      cyc({nm, "/FR"}, 1'b1, 1'b0, 1'b0, E(ST_FETCH_REGS, "g"));
   endtask

   task automatic rst1(input string nm);
      cyc(nm, 1'b0, 1'b0, 1'b0, E(4'd0, ""));
   endtask

   initial begin : monitor
      out_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (q_exp.size() != 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_checks++;
            if (act !== e) begin
               n_errors++;
               $display("FAIL %s: actual=%h required=%h", nm, act, e);
            end
         end
      end
   end

   initial begin : stimulus
      opcode      = OP_ALUREG;
      take_branch = 1'b0;
      mem_rbusy   = 1'b0;
      mem_wbusy   = 1'b0;
      resetn      = 1'b0;
      @(posedge clk);
      #1;
      rst1("reset0");
      cyc("reset1", 1'b0, 1'b1, 1'b1, E(4'd0, ""));

      opcode = OP_ALUREG;
      front("alureg");
      cyc("alureg/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "dpt", PCSEL_PLUS4));
      opcode = OP_LUI;
      front("lui");
      cyc("lui/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "dpt", PCSEL_PLUS4));
      opcode = OP_JAL;
      front("jal");
      cyc("jal/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "dpt", PCSEL_IMM));
      opcode = OP_JALR;
      front("jalr");
      cyc("jalr/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "dpt", PCSEL_RS1));

      opcode      = OP_BRANCH;
      take_branch = 1'b1;
      front("br1");
      cyc("br1/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "pt", PCSEL_IMM));
      take_branch = 1'b0;
      front("br0");
      cyc("br0/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "pt", PCSEL_PLUS4));

      opcode = OP_LOAD;
      front("ld");
      cyc("ld/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "p"));
      cyc("ld/LD", 1'b1, 1'b1, 1'b0, E(ST_LOAD, "ra"));
      for (int i = 0; i < 3; i++)
         cyc("ld/WD_busy", 1'b1, 1'b1, 1'b0, E(ST_WAIT_DATA, "a"));
      cyc("ld/WD_done", 1'b1, 1'b0, 1'b0, E(ST_WAIT_DATA, "adlt"));

      opcode = OP_STORE;
      front("st");
      cyc("st/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "p"));
      cyc("st/ST", 1'b1, 1'b0, 1'b0, E(ST_STORE, "wa"));
      cyc("st/WS", 1'b1, 1'b0, 1'b0, E(ST_WAIT_STORE, "t"));

      front("sttmo");
      cyc("sttmo/EX", 1'b1, 1'b0, 1'b1, E(ST_EXECUTE, "p"));
      cyc("sttmo/ST", 1'b1, 1'b0, 1'b1, E(ST_STORE, "wa"));
      for (int i = 0; i < 8; i++)
         cyc("sttmo/WS", 1'b1, 1'b0, 1'b1, E(ST_WAIT_STORE, ""));
      cyc("sttmo/HALT0", 1'b1, 1'b0, 1'b1, E(ST_HALT, "ho"));
      cyc("sttmo/HALT1", 1'b1, 1'b0, 1'b0, E(ST_HALT, "ho"));
      rst1("sttmo/reset");

      opcode = OP_SYSTEM;
      front("sys");
      cyc("sys/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, ""));
      for (int i = 0; i < 20; i++)
         cyc("sys/HALT", 1'b1, 1'b0, 1'b0, E(ST_HALT, "h"));
      rst1("sys/reset");

      opcode = 7'b1111111;
      front("ill");
      cyc("ill/EX", 1'b1, 1'b0, 1'b0, E(ST_EXECUTE, ""));
      for (int i = 0; i < 3; i++)
         cyc("ill/HALT", 1'b1, 1'b0, 1'b0, E(ST_HALT, "hx"));
      rst1("ill/reset");

      opcode = OP_ALUREG;
      cyc("abort/F",   1'b1, 1'b1, 1'b0, E(ST_FETCH_INSTR, "r"));
      cyc("abort/WI0", 1'b1, 1'b1, 1'b0, E(ST_WAIT_INSTR, ""));
      cyc("abort/WI1", 1'b1, 1'b1, 1'b0, E(ST_WAIT_INSTR, ""));
      cyc("abort/rst", 1'b0, 1'b1, 1'b0, E(4'd0, ""));
      cyc("abort/F2",  1'b1, 1'b1, 1'b0, E(ST_FETCH_INSTR, "r"));
      cyc("abort/WI2", 1'b1, 1'b1, 1'b0, E(ST_WAIT_INSTR, ""));
      cyc("abort/WI3", 1'b1, 1'b0, 1'b0, E(ST_WAIT_INSTR, "i"));
      cyc("abort/FR",  1'b1, 1'b0, 1'b0, E(ST_FETCH_REGS, "g"));
      cyc("abort/EX",  1'b1, 1'b0, 1'b0, E(ST_EXECUTE, "dpt"));

      for (int k = 0; k < 10 && q_exp.size() != 0; k++)
         @(negedge clk);
      if (q_exp.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: actual=%0d pending required=0", q_exp.size());
      end
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
